// File: rtl/tp84_lpf_sched.sv
// rtl/tp84_lpf_sched.sv - time-multiplexed 1st-order IIR low-pass scheduler shared across NCH channels
module tp84_lpf_sched #(
    parameter int NCH = 4,
    parameter int DIV = 220
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [16*NCH-1:0]   in,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_ch,
    input  logic [1:0]          cfg_sel,
    input  logic signed [17:0]  cfg_data,
    output logic [16*NCH-1:0]   out,
    output logic                out_valid,
    output logic                busy
);

    localparam int DIVW = $clog2(DIV);

    localparam logic signed [17:0] B1_DEF = 18'sd1489;
    localparam logic signed [17:0] B2_DEF = 18'sd1489;
    localparam logic signed [17:0] A2_DEF = -18'sd29791;

    // A sweep must finish before the next tick can arrive.
    if (DIV < 4*NCH+2) begin : g_div_check
        $error("tp84_lpf_sched: DIV must be >= 4*NCH+2");
    end
    if (NCH < 1 || NCH > 8) begin : g_nch_check
        $error("tp84_lpf_sched: NCH must be in 1..8");
    end

    typedef enum logic [2:0] {IDLE, S_X, S_X1, S_Y1, S_WB} state_t;

    state_t                 state;
    logic [2:0]             ch;
    logic [DIVW-1:0]        div_cnt;
    logic                   tick;

    logic signed [17:0]     b1_sh [NCH];
    logic signed [17:0]     b2_sh [NCH];
    logic signed [17:0]     a2_sh [NCH];
    logic signed [17:0]     b1_nx [NCH];
    logic signed [17:0]     b2_nx [NCH];
    logic signed [17:0]     a2_nx [NCH];
    logic signed [17:0]     b1_act [NCH];
    logic signed [17:0]     b2_act [NCH];
    logic signed [17:0]     a2_act [NCH];

    logic signed [15:0]     x1 [NCH];
    logic signed [15:0]     y1 [NCH];
    logic signed [15:0]     x_reg;
    logic signed [37:0]     acc;

    logic signed [15:0]     cur_in;
    logic signed [15:0]     cur_x1;
    logic signed [15:0]     cur_y1;
    logic signed [17:0]     cur_b1;
    logic signed [17:0]     cur_b2;
    logic signed [17:0]     cur_a2;

    logic signed [17:0]     mul_a;
    logic signed [17:0]     mul_b;
    logic signed [35:0]     prod;
    logic signed [37:0]     prod_ext;
    logic signed [37:0]     acc_sh;
    logic signed [15:0]     y_sat;

    assign tick = (div_cnt == DIVW'(DIV-1));

    // Free-running sample divider, wraps at DIV-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Shadow contents after this cycle's write, so a tick-cycle write reaches the active set.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            b1_nx[k] = b1_sh[k];
            b2_nx[k] = b2_sh[k];
            a2_nx[k] = a2_sh[k];
            if (cfg_we && cfg_ch == 3'(k)) begin
                case (cfg_sel)
                    2'd0:    b1_nx[k] = cfg_data;
                    2'd1:    b2_nx[k] = cfg_data;
                    2'd2:    a2_nx[k] = cfg_data;
                    default: ;
                endcase
            end
        end
    end

    // Shadow registers take writes anytime; active set is refreshed only on the tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NCH; k++) begin
                b1_sh[k]  <= B1_DEF;
                b2_sh[k]  <= B2_DEF;
                a2_sh[k]  <= A2_DEF;
                b1_act[k] <= B1_DEF;
                b2_act[k] <= B2_DEF;
                a2_act[k] <= A2_DEF;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                b1_sh[k] <= b1_nx[k];
                b2_sh[k] <= b2_nx[k];
                a2_sh[k] <= a2_nx[k];
                if (tick) begin
                    b1_act[k] <= b1_nx[k];
                    b2_act[k] <= b2_nx[k];
                    a2_act[k] <= a2_nx[k];
                end
            end
        end
    end

    // Select the state and coefficients of the channel currently being processed.
    always_comb begin
        cur_in = '0;
        cur_x1 = '0;
        cur_y1 = '0;
        cur_b1 = '0;
        cur_b2 = '0;
        cur_a2 = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch == 3'(k)) begin
                cur_in = in[16*k +: 16];
                cur_x1 = x1[k];
                cur_y1 = y1[k];
                cur_b1 = b1_act[k];
                cur_b2 = b2_act[k];
                cur_a2 = a2_act[k];
            end
        end
    end

    // Operand steering for the single shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_X: begin
                mul_a = cur_b1;
                mul_b = {{2{cur_in[15]}}, cur_in};
            end
            S_X1: begin
                mul_a = cur_b2;
                mul_b = {{2{cur_x1[15]}}, cur_x1};
            end
            S_Y1: begin
                mul_a = cur_a2;
                mul_b = {{2{cur_y1[15]}}, cur_y1};
            end
            default: ;
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{2{prod[35]}}, prod};
    assign acc_sh   = acc >>> 15;

    // Q2.15 rescale with clamp to the 16-bit output range.
    always_comb begin
        if (acc_sh > 38'sd32767) begin
            y_sat = 16'sh7FFF;
        end else if (acc_sh < -38'sd32768) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = acc_sh[15:0];
        end
    end

    // Channel sweep: four fixed cycles per channel, outputs and history updated in S_WB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ch        <= '0;
            acc       <= '0;
            x_reg     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                x1[k] <= '0;
                y1[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= S_X;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_X: begin
                    x_reg <= cur_in;
                    acc   <= prod_ext;
                    state <= S_X1;
                end
                S_X1: begin
                    acc   <= acc + prod_ext;
                    state <= S_Y1;
                end
                S_Y1: begin
                    acc   <= acc - prod_ext;
                    state <= S_WB;
                end
                S_WB: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (ch == 3'(k)) begin
                            out[16*k +: 16] <= y_sat;
                            y1[k]           <= y_sat;
                            x1[k]           <= x_reg;
                        end
                    end
                    if (ch == 3'(NCH-1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        ch    <= ch + 3'd1;
                        state <= S_X;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tp84_lpf_sched.sv
// tb/tb_tp84_lpf_sched.sv - self-checking bench for tp84_lpf_sched against a per-sweep filter model
module tb_tp84_lpf_sched;

    localparam int NCH = 4;
    localparam int DIV = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [16*NCH-1:0]   in;
    logic                cfg_we;
    logic [2:0]          cfg_ch;
    logic [1:0]          cfg_sel;
    logic [17:0]         cfg_data;
    logic [16*NCH-1:0]   out;
    logic                out_valid;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid = -1;

    int m_in [NCH];
    int m_x1 [NCH];
    int m_y1 [NCH];
    int sh_b1 [NCH];
    int sh_b2 [NCH];
    int sh_a2 [NCH];
    int ac_b1 [NCH];
    int ac_b2 [NCH];
    int ac_a2 [NCH];

    tp84_lpf_sched #(.NCH(NCH), .DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_ch(input int k);
        return int'($signed(out[16*k +: 16]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_x1[k] = 0;  m_y1[k] = 0;
            sh_b1[k] = 1489; sh_b2[k] = 1489; sh_a2[k] = -29791;
            ac_b1[k] = 1489; ac_b2[k] = 1489; ac_a2[k] = -29791;
        end
    endtask

    task automatic set_in(input int k, input int v);
        m_in[k] = v;
        in[16*k +: 16] = 16'(v);
    endtask

    // Drives one write for a single cycle; called at a negedge, returns at the next one.
    task automatic cfg_write(input int c, input int sel, input int val);
        cfg_we   = 1'b1;
        cfg_ch   = 3'(c);
        cfg_sel  = 2'(sel);
        cfg_data = 18'(val);
        if (c < NCH) begin
            if (sel == 0) sh_b1[c] = val;
            else if (sel == 1) sh_b2[c] = val;
            else if (sel == 2) sh_a2[c] = val;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // First busy cycle of a sweep: coefficients seen by this sweep are frozen here.
    task automatic sweep_start();
        int n = 0;
        while (busy !== 1'b1 && n < 3*DIV) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rise", longint'(busy), 1);
        for (int k = 0; k < NCH; k++) begin
            ac_b1[k] = sh_b1[k]; ac_b2[k] = sh_b2[k]; ac_a2[k] = sh_a2[k];
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 3*DIV) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", longint'(out_valid), 1);
        chk("busy_at_valid", longint'(busy), 0);
        if (last_valid >= 0) chk("valid_period", cyc - last_valid, DIV);
        last_valid = cyc;
    endtask

    // y = clamp(floor((b1*x + b2*x1 - a2*y1) / 2^15)) for every channel.
    task automatic check_outputs(input string tag);
        for (int k = 0; k < NCH; k++) begin
            longint acc;
            longint y;
            acc = longint'(ac_b1[k]) * m_in[k] + longint'(ac_b2[k]) * m_x1[k]
                - longint'(ac_a2[k]) * m_y1[k];
            y = acc >>> 15;
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            chk($sformatf("%s_ch%0d", tag, k), out_ch(k), y);
            m_x1[k] = m_in[k];
            m_y1[k] = int'(y);
        end
    endtask

    task automatic sweep(input string tag);
        sweep_start();
        wait_valid();
        check_outputs(tag);
    endtask

    // Holds reset for n edges, then measures the first out_valid and checks that sweep.
    task automatic reset_and_measure(input int n);
        int cnt;
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
        model_reset();
        chk("rst_out_zero", longint'(out != '0), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < DIV + 4*NCH + 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_valid_cycle", cnt, DIV + 4*NCH + 1);
        last_valid = cyc;
        check_outputs("post_reset");
    endtask

    initial begin
        int prev;
        reset    = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_sel  = '0;
        cfg_data = '0;
        in       = '0;
        model_reset();

        // Reset with full-scale inputs present
        for (int k = 0; k < NCH; k++) set_in(k, 32767);
        reset_and_measure(3);

        // Averager: zero history first, then two sweeps on ch0
        for (int k = 0; k < NCH; k++) set_in(k, 0);
        reset_and_measure(2);
        for (int k = 0; k < NCH; k++) begin
            cfg_write(k, 0, 16384);
            cfg_write(k, 1, 16384);
            cfg_write(k, 2, 0);
        end
        set_in(0, 1000);
        sweep("avg1");
        chk("avg_first", out_ch(0), 500);
        set_in(0, 3000);
        sweep("avg2");
        chk("avg_second", out_ch(0), 2000);

        // DC step through default coefficients on ch1
        for (int k = 0; k < NCH; k++) set_in(k, 0);
        reset_and_measure(2);
        set_in(1, 16000);
        prev = out_ch(1);
        for (int s = 0; s < 400; s++) begin
            sweep("dc");
            chk("dc_monotonic", longint'(out_ch(1) >= prev), 1);
            prev = out_ch(1);
        end
        chk("dc_final_range", longint'(out_ch(1) >= 15990 && out_ch(1) <= 16010), 1);
        chk("dc_ch0_zero", out_ch(0), 0);

        // Saturation on ch2
        set_in(1, 0);
        reset_and_measure(2);
        cfg_write(2, 0, 32767);
        cfg_write(2, 1, 32767);
        cfg_write(2, 2, -32768);
        set_in(2, 32767);
        for (int s = 0; s < 4; s++) begin
            sweep("sat_pos");
            if (s >= 1) chk("sat_pos_clamp", out_ch(2), 32767);
        end
        set_in(2, -32768);
        for (int s = 0; s < 4; s++) sweep("sat_neg");
        chk("sat_neg_clamp", out_ch(2), -32768);

        // Shadow timing on ch3: mid-sweep writes wait, tick-cycle write goes through
        set_in(2, 0);
        set_in(3, 20000);
        sweep("sh_pre");
        sweep_start();
        cfg_write(3, 0, 0);
        cfg_write(3, 1, 0);
        cfg_write(3, 2, 0);
        wait_valid();
        check_outputs("sh_cur");
        sweep("sh_next");
        chk("sh_ch3_zero", out_ch(3), 0);
        repeat (DIV - 4*NCH - 1) @(negedge clk);
        chk("idle_before_tick", longint'(busy), 0);
        cfg_write(3, 0, 16384);
        sweep_start();
        wait_valid();
        check_outputs("sh_tick");
        chk("sh_tick_write", out_ch(3), 10000);

        // Randomized inputs and coefficient writes, idle and mid-sweep, including ignored targets
        for (int s = 0; s < 30; s++) begin
            int nw;
            for (int k = 0; k < NCH; k++) set_in(k, int'($urandom_range(0, 65535)) - 32768);
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++)
                cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 65535)) - 32768);
            sweep_start();
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++)
                cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 65535)) - 32768);
            wait_valid();
            check_outputs("rand");
        end

        // Reset during ch1 S_Y1 aborts the sweep and restores defaults
        for (int k = 0; k < NCH; k++) set_in(k, 5000 * (k + 1));
        sweep_start();
        repeat (6) @(negedge clk);
        reset_and_measure(1);
        sweep("post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
